// File: rtl/pipelined_word_mux_if.sv
// Handshake bundle for pipelined_word_mux: input channel side and output word side.
// MUX_PARITY_EN adds the registered out_par signal to the bundle.
interface pipelined_word_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SEL_W = 3
);
    logic [N*WIDTH-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;
`ifdef MUX_PARITY_EN
    logic               out_par;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_sel, out_valid, out_par
    );
    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_sel, out_valid, out_par
    );
`else
    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
`endif
endinterface

// File: rtl/pipelined_word_mux.sv
// Two-stage N:1 word mux: stage A picks within groups of four, stage B picks the group.
// Optional MUX_PARITY_EN adds a registered odd-parity flag alongside out_data.
module pipelined_word_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_word_mux_if.slave   bus
);
    localparam int G = N / 4;

    logic [WIDTH-1:0] quad_w    [G][4];
    logic [WIDTH-1:0] grp_a_reg [G];
    logic [WIDTH-1:0] b_word;

    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] idx_a_reg;
    logic [SEL_W-1:0] scan_idx_reg;
    logic [SEL_W-1:0] scan_idx_next;
    logic             v_a_reg;

    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_sel_reg;
    logic             out_valid_reg;

    logic rdy_a;
    logic rdy_b;
    logic accept;
    logic move;

    assign rdy_b  = !out_valid_reg || bus.out_ready;
    assign rdy_a  = !v_a_reg || rdy_b;
    assign accept = bus.in_valid && rdy_a;
    assign move   = v_a_reg && rdy_b;
    assign idx    = bus.mode ? scan_idx_reg : bus.sel;

    genvar gi, gj;
    generate
        for (gi = 0; gi < G; gi++) begin : g_grp
            for (gj = 0; gj < 4; gj++) begin : g_lane
                assign quad_w[gi][gj] = bus.in_data[(4*gi + gj)*WIDTH +: WIDTH];
            end
        end
        if (G > 1) begin : g_multi
            assign b_word = grp_a_reg[idx_a_reg[SEL_W-1:2]];
        end else begin : g_single
            assign b_word = grp_a_reg[0];
        end
    endgenerate

    // Scan position only advances on words actually accepted while scanning.
    always_comb begin
        scan_idx_next = scan_idx_reg;
        if (!bus.mode) begin
            scan_idx_next = '0;
        end else if (accept) begin
            scan_idx_next = scan_idx_reg + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < G; i++) begin
                grp_a_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < G; i++) begin
                grp_a_reg[i] <= quad_w[i][idx[1:0]];
            end
        end
    end

    // A reload has priority over A emptying so a same-edge move+accept keeps vA set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_a_reg      <= 1'b0;
            idx_a_reg    <= '0;
            scan_idx_reg <= '0;
        end else begin
            scan_idx_reg <= scan_idx_next;
            if (accept) begin
                v_a_reg   <= 1'b1;
                idx_a_reg <= idx;
            end else if (move) begin
                v_a_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else if (move) begin
            out_data_reg  <= b_word;
            out_sel_reg   <= idx_a_reg;
            out_valid_reg <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef MUX_PARITY_EN
    logic out_par_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_reg <= 1'b0;
        end else if (move) begin
            out_par_reg <= ^b_word;
        end
    end

    assign bus.out_par = out_par_reg;
`endif

    assign bus.in_ready  = rdy_a;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sel   = out_sel_reg;
    assign bus.out_valid = out_valid_reg;

endmodule
